bios_rom_responder: RTL

BIOS_ROM_RESPONDER -- requirements
Module: bios_rom_responder

---
 rtl/busdefs_pkg.sv | 34 +++
 rtl/rom_tag_pipe.sv | 41 ++++
 rtl/bios_rom_responder.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/busdefs_pkg.sv
// Shared bus-responder definitions: bus-cycle state encodings, ROM window
// defaults and small byte-lane helpers used by the BIOS ROM responder.
package busdefs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bus_state_e;

  localparam logic [31:0] ROM_BASE_DEFAULT = 32'h000F_0000;
  localparam logic [31:0] OOW_FILL         = 32'hFFFF_FFFF;
  localparam logic [1:0]  LAST_BYTE        = 2'd3;

  function automatic logic in_window(input logic [15:0] addr_hi, input logic [15:0] base_hi);
    return (addr_hi == base_hi);
  endfunction

  // Byte 3 is never stored here: it completes the word directly.
  function automatic logic [23:0] put_byte(input logic [23:0] word, input logic [1:0] idx,
                                           input logic [7:0] data);
    logic [23:0] w;
    w = word;
    case (idx)
      2'd0:    w[7:0]   = data;
      2'd1:    w[15:8]  = data;
      2'd2:    w[23:16] = data;
      default: w        = word;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rom_tag_pipe.sv
// Delay line that follows each ROM strobe and its byte index so the byte can be
// captured exactly DEPTH cycles after the strobe was presented to the ROM.
module rom_tag_pipe
  import busdefs_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] in_idx,
  output logic       out_valid,
  output logic [1:0] out_idx
);

  localparam int unsigned IW = 2 * DEPTH;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [IW-1:0]    idx_q, idx_d;

  // Shift every stage one step towards the output.
  always_comb begin
    valid_d = (valid_q << 1'b1) | DEPTH'(in_valid);
    idx_d   = (idx_q << 2'd2) | IW'(in_idx);
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      idx_q   <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_idx   = idx_q[IW-1 -: 2];

endmodule

// File: rtl/bios_rom_responder.sv
// Memory-bus responder for the 64 KB BIOS ROM window: assembles 32-bit reads
// from four byte fetches, acknowledges and drops writes, fills reads outside the window.
module bios_rom_responder
  import busdefs_pkg::*;
#(
  parameter logic [31:0] ROM_BASE    = ROM_BASE_DEFAULT,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bus_address,
  input  logic        bus_rd_enable,
  output logic [31:0] bus_rd_data,
  output logic        bus_rd_valid,
  input  logic        bus_wr_enable,
  input  logic [31:0] bus_wr_data,
  input  logic [3:0]  bus_wr_mask,
  output logic        bus_wr_ack,
  output logic        bus_busy,
  output logic [15:0] rom_address,
  output logic        rom_rd_enable,
  input  logic [7:0]  rom_rd_data
);

  localparam int unsigned PIPE_DEPTH = (ROM_LATENCY < 32'd1) ? 32'd1 :
                                       (ROM_LATENCY > 32'd4) ? 32'd4 : ROM_LATENCY;

  bus_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [13:0] word_addr_q, word_addr_d;
  logic [23:0] word_q, word_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        wr_ack_q, wr_ack_d;
  logic        busy_q, busy_d;
  logic        rom_en_q, rom_en_d;
  logic [15:0] rom_addr_q, rom_addr_d;

  logic        tag_valid;
  logic [1:0]  tag_idx;
  logic        last_byte;
  logic        hit;
  logic        unused_inputs;

  // Write payload and byte offset within the word carry no information for a ROM.
  assign unused_inputs = ^{bus_wr_data, bus_wr_mask, bus_address[1:0]};

  assign hit       = in_window(bus_address[31:16], ROM_BASE[31:16]);
  assign last_byte = tag_valid && (tag_idx == LAST_BYTE);

  rom_tag_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rom_en_q),
    .in_idx    (rom_addr_q[1:0]),
    .out_valid (tag_valid),
    .out_idx   (tag_idx)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      word_addr_q <= 14'd0;
      word_q      <= 24'd0;
      rd_data_q   <= 32'd0;
      rd_valid_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_addr_q <= word_addr_d;
      word_q      <= word_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      wr_ack_q    <= wr_ack_d;
      busy_q      <= busy_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_rd_enable && hit) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (cnt_q == LAST_BYTE) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (last_byte) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; all bus-facing outputs leave from flops.
  always_comb begin
    cnt_d       = cnt_q;
    word_addr_d = word_addr_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rom_en_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    busy_d      = (state_d != ST_IDLE);

    if ((state_q == ST_IDLE) && bus_wr_enable) begin
      wr_ack_d = 1'b1;
    end else begin
      wr_ack_d = 1'b0;
    end

    // Bytes land in the scratch word so bus_rd_data stays stable until completion.
    if (tag_valid) begin
      word_d = put_byte(word_q, tag_idx, rom_rd_data);
    end else begin
      word_d = word_q;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = 2'd0;
        if (bus_rd_enable && hit) begin
          word_addr_d = bus_address[15:2];
        end else if (bus_rd_enable) begin
          rd_valid_d = 1'b1;
          rd_data_d  = OOW_FILL;
        end else begin
          word_addr_d = word_addr_q;
        end
      end
      ST_FETCH: begin
        rom_en_d   = 1'b1;
        rom_addr_d = {word_addr_q, cnt_q};
        cnt_d      = cnt_q + 2'd1;
      end
      ST_DRAIN: begin
        if (last_byte) begin
          rd_valid_d = 1'b1;
          rd_data_d  = {rom_rd_data, word_q};
        end else begin
          rd_valid_d = 1'b0;
        end
      end
      ST_DONE: begin
        cnt_d = 2'd0;
      end
      default: begin
        cnt_d = 2'd0;
      end
    endcase
  end

  assign bus_rd_data   = rd_data_q;
  assign bus_rd_valid  = rd_valid_q;
  assign bus_wr_ack    = wr_ack_q;
  assign bus_busy      = busy_q;
  assign rom_address   = rom_addr_q;
  assign rom_rd_enable = rom_en_q;

endmodule
